// File: rtl/crank_event_scheduler.sv
// Missing-tooth crank decoder: finds the gap, tracks the tooth index and emits a
// one-cycle trigger with its latched delay when the programmed event tooth passes.
module crank_event_scheduler #(
  parameter int unsigned TOOTH_BITS  = 8,
  parameter int unsigned PERIOD_BITS = 24,
  parameter int unsigned DELAY_BITS  = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tooth_in,
  input  logic [TOOTH_BITS-1:0] teeth_per_rev,
  input  logic [TOOTH_BITS-1:0] event_tooth,
  input  logic [DELAY_BITS-1:0] event_delay,
  input  logic                  arm,
  output logic                  trigger,
  output logic [DELAY_BITS-1:0] trigger_delay,
  output logic [TOOTH_BITS-1:0] tooth_index,
  output logic                  synced,
  output logic                  sync_loss
);

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_SYNCING = 2'd1,
    ST_SYNCED  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    s1_q, s2_q, s3_q;
  logic [PERIOD_BITS-1:0]  cnt_q, cnt_d;
  logic [PERIOD_BITS-1:0]  prev_q, prev_d;
  logic [TOOTH_BITS-1:0]   idx_q, idx_d;
  logic                    trig_q, trig_d;
  logic                    loss_q, loss_d;
  logic                    synced_q, synced_d;
  logic [DELAY_BITS-1:0]   tdly_q, tdly_d;

  logic                    edge_det;
  logic                    stall;
  logic                    gap;
  logic                    last_tooth;
  logic [PERIOD_BITS:0]    gap_limit;

  assign edge_det   = s2_q & ~s3_q;
  assign stall      = &cnt_q;
  // One extra bit so 1.5x the previous period cannot wrap.
  assign gap_limit  = {1'b0, prev_q} + {2'b00, prev_q[PERIOD_BITS-1:1]};
  assign gap        = (prev_q != '0) && ({1'b0, cnt_q} > gap_limit);
  assign last_tooth = (idx_q == teeth_per_rev - TOOTH_BITS'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_UNSYNC;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      trig_q   <= 1'b0;
      loss_q   <= 1'b0;
      synced_q <= 1'b0;
      tdly_q   <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= tooth_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      trig_q   <= trig_d;
      loss_q   <= loss_d;
      synced_q <= synced_d;
      tdly_q   <= tdly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNSYNC: begin
        if (edge_det) state_d = ST_SYNCING;
      end
      ST_SYNCING: begin
        if (stall)                state_d = ST_UNSYNC;
        else if (edge_det && gap) state_d = ST_SYNCED;
      end
      ST_SYNCED: begin
        // A gap must coincide with the last tooth; either alone means lost position.
        if (stall)                            state_d = ST_UNSYNC;
        else if (edge_det && (gap ^ last_tooth)) state_d = ST_SYNCING;
      end
      default: state_d = ST_UNSYNC;
    endcase
  end

  always_comb begin
    cnt_d    = stall ? cnt_q : cnt_q + PERIOD_BITS'(1);
    prev_d   = prev_q;
    idx_d    = idx_q;
    trig_d   = 1'b0;
    tdly_d   = tdly_q;
    loss_d   = (state_q == ST_SYNCED) && (state_d != ST_SYNCED);
    synced_d = (state_d == ST_SYNCED);

    if (edge_det) begin
      cnt_d  = PERIOD_BITS'(1);
      prev_d = (state_q == ST_UNSYNC) ? '0 : cnt_q;
    end

    if ((state_q == ST_SYNCING) && (state_d == ST_SYNCED)) begin
      idx_d = '0;
    end else if (edge_det && (state_q == ST_SYNCED) && (state_d == ST_SYNCED)) begin
      idx_d = gap ? '0 : idx_q + TOOTH_BITS'(1);
      if (arm && (idx_d == event_tooth)) begin
        trig_d = 1'b1;
        tdly_d = event_delay;
      end
    end
  end

  assign trigger       = trig_q;
  assign trigger_delay = tdly_q;
  assign tooth_index   = idx_q;
  assign synced        = synced_q;
  assign sync_loss     = loss_q;

endmodule

// File: tb/tb_crank_event_scheduler.sv
// Directed bench for crank_event_scheduler on a 36-1 wheel (100-clk teeth, 200-clk gap).
module tb_crank_event_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tooth_in;
  logic [7:0]  teeth_per_rev;
  logic [7:0]  event_tooth;
  logic [23:0] event_delay;
  logic        arm;
  logic        trigger;
  logic [23:0] trigger_delay;
  logic [7:0]  tooth_index;
  logic        synced;
  logic        sync_loss;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int loss_cnt = 0;
  int both_cnt = 0;
  logic [7:0]  last_idx = '0;
  logic [23:0] last_dly = '0;

  always #5 clk = ~clk;

  crank_event_scheduler #(
    .TOOTH_BITS (8),
    .PERIOD_BITS(12),
    .DELAY_BITS (24)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tooth_in     (tooth_in),
    .teeth_per_rev(teeth_per_rev),
    .event_tooth  (event_tooth),
    .event_delay  (event_delay),
    .arm          (arm),
    .trigger      (trigger),
    .trigger_delay(trigger_delay),
    .tooth_index  (tooth_index),
    .synced       (synced),
    .sync_loss    (sync_loss)
  );

  always @(negedge clk) begin
    if (trigger) begin
      trig_cnt = trig_cnt + 1;
      last_idx = tooth_index;
      last_dly = trigger_delay;
    end
    if (sync_loss) loss_cnt = loss_cnt + 1;
    if (trigger && sync_loss) both_cnt = both_cnt + 1;
  end

  // One tooth: rising edge now, then `interval` clocks until the next tooth.
  task automatic tooth(input int unsigned interval);
    tooth_in = 1'b1;
    repeat (interval / 2) @(posedge clk);
    #1 tooth_in = 1'b0;
    repeat (interval - interval / 2) @(posedge clk);
    #1;
  endtask

  task automatic run_teeth(input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i <= last; i++) tooth((i == 34) ? 200 : 100);
  endtask

  task automatic presync();
    run_teeth(30, 34);
    tooth(100);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tooth_in = 1'b0; arm = 1'b0;
    teeth_per_rev = 8'd35; event_tooth = 8'd5; event_delay = 24'd1000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got %0b exp 0", trigger); end
    checks++; if (trigger_delay !== 24'd0) begin errors++; $display("FAIL reset_delay got %0d exp 0", trigger_delay); end
    checks++; if (tooth_index !== 8'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", tooth_index); end
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL reset_synced got %0b exp 0", synced); end
    checks++; if (sync_loss !== 1'b0) begin errors++; $display("FAIL reset_loss got %0b exp 0", sync_loss); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sync();
    int l0, t0;
    l0 = loss_cnt; t0 = trig_cnt;
    presync();
    checks++; if (synced !== 1'b1 || tooth_index !== 8'd0) begin errors++; $display("FAIL sync_first got synced=%0b idx=%0d exp synced=1 idx=0", synced, tooth_index); end
    run_teeth(1, 34);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i <= 34; i++) begin
        tooth((i == 34) ? 200 : 100);
        checks++;
        if (tooth_index !== 8'(i) || synced !== 1'b1) begin
          errors++; $display("FAIL sync_index rev%0d got idx=%0d synced=%0b exp idx=%0d synced=1", r, tooth_index, synced, i);
        end
      end
    end
    checks++; if (loss_cnt !== l0) begin errors++; $display("FAIL sync_no_loss got %0d exp %0d", loss_cnt, l0); end
    checks++; if (trig_cnt !== t0) begin errors++; $display("FAIL sync_unarmed_trig got %0d exp %0d", trig_cnt, t0); end
  endtask

  task automatic test_event();
    int t0;
    logic [23:0] exp_dly;
    t0 = trig_cnt;
    arm = 1'b1; event_tooth = 8'd5;
    for (int r = 0; r < 2; r++) begin
      exp_dly = (r == 0) ? 24'd1000 : 24'd2222;
      event_delay = exp_dly;
      for (int i = 0; i <= 34; i++) begin
        if (i == 5) begin
          tooth_in = 1'b1;
          @(posedge clk); #1;
          checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL event_early1 got %0b exp 0", trigger); end
          @(posedge clk); #1;
          checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL event_early2 got %0b exp 0", trigger); end
          @(posedge clk); #1;
          checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL event_fire got %0b exp 1", trigger); end
          checks++; if (tooth_index !== 8'd5) begin errors++; $display("FAIL event_index got %0d exp 5", tooth_index); end
          checks++; if (trigger_delay !== exp_dly) begin errors++; $display("FAIL event_delay got %0d exp %0d", trigger_delay, exp_dly); end
          event_delay = 24'd7;
          @(posedge clk); #1;
          checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL event_width got %0b exp 0", trigger); end
          repeat (46) @(posedge clk);
          #1 tooth_in = 1'b0;
          repeat (50) @(posedge clk);
          #1;
        end else begin
          tooth((i == 34) ? 200 : 100);
        end
      end
      checks++; if (trigger_delay !== exp_dly) begin errors++; $display("FAIL event_hold got %0d exp %0d", trigger_delay, exp_dly); end
      checks++; if (trig_cnt !== t0 + r + 1) begin errors++; $display("FAIL event_count got %0d exp %0d", trig_cnt, t0 + r + 1); end
    end
  endtask

  task automatic test_no_fire();
    int t0, l0;
    t0 = trig_cnt; l0 = loss_cnt;
    arm = 1'b0; event_tooth = 8'd5;
    run_teeth(0, 34);
    checks++; if (trig_cnt !== t0) begin errors++; $display("FAIL nofire_disarmed got %0d exp %0d", trig_cnt, t0); end
    checks++; if (synced !== 1'b1) begin errors++; $display("FAIL nofire_synced got %0b exp 1", synced); end
    arm = 1'b1; event_tooth = 8'd35;
    run_teeth(0, 34);
    checks++; if (trig_cnt !== t0) begin errors++; $display("FAIL nofire_out_of_range got %0d exp %0d", trig_cnt, t0); end
    event_tooth = 8'd34; event_delay = 24'h00ABCD;
    run_teeth(0, 34);
    checks++; if (trig_cnt !== t0 + 1) begin errors++; $display("FAIL last_tooth_count got %0d exp %0d", trig_cnt, t0 + 1); end
    checks++; if (last_idx !== 8'd34) begin errors++; $display("FAIL last_tooth_index got %0d exp 34", last_idx); end
    checks++; if (last_dly !== 24'h00ABCD) begin errors++; $display("FAIL last_tooth_delay got %0h exp abcd", last_dly); end
    checks++; if (loss_cnt !== l0) begin errors++; $display("FAIL nofire_loss got %0d exp %0d", loss_cnt, l0); end
  endtask

  task automatic test_extra_tooth();
    int t0, l0;
    arm = 1'b1; event_tooth = 8'd0; l0 = loss_cnt;
    run_teeth(0, 33);
    tooth(100);
    t0 = trig_cnt;
    tooth_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sync_loss !== 1'b1) begin errors++; $display("FAIL extra_loss got %0b exp 1", sync_loss); end
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL extra_synced got %0b exp 0", synced); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL extra_trigger got %0b exp 0", trigger); end
    @(posedge clk); #1;
    checks++; if (sync_loss !== 1'b0) begin errors++; $display("FAIL extra_loss_width got %0b exp 0", sync_loss); end
    repeat (46) @(posedge clk);
    #1 tooth_in = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    tooth(100);
    checks++; if (synced !== 1'b1 || tooth_index !== 8'd0) begin errors++; $display("FAIL extra_resync got synced=%0b idx=%0d exp synced=1 idx=0", synced, tooth_index); end
    checks++; if (trig_cnt !== t0) begin errors++; $display("FAIL extra_resync_trig got %0d exp %0d", trig_cnt, t0); end
    run_teeth(1, 34);
    checks++; if (loss_cnt !== l0 + 1) begin errors++; $display("FAIL extra_loss_count got %0d exp %0d", loss_cnt, l0 + 1); end
    checks++; if (tooth_index !== 8'd34) begin errors++; $display("FAIL extra_final_idx got %0d exp 34", tooth_index); end
  endtask

  task automatic test_stall();
    int l0;
    arm = 1'b0; l0 = loss_cnt;
    tooth_in = 1'b0;
    repeat (4200) @(posedge clk);
    #1;
    checks++; if (loss_cnt !== l0 + 1) begin errors++; $display("FAIL stall_loss got %0d exp %0d", loss_cnt, l0 + 1); end
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL stall_synced got %0b exp 0", synced); end
    presync();
    checks++; if (synced !== 1'b1 || tooth_index !== 8'd0) begin errors++; $display("FAIL stall_resync got synced=%0b idx=%0d exp synced=1 idx=0", synced, tooth_index); end
    run_teeth(1, 34);
    checks++; if (loss_cnt !== l0 + 1) begin errors++; $display("FAIL stall_single_loss got %0d exp %0d", loss_cnt, l0 + 1); end
  endtask

  task automatic test_reset_midrev();
    int t0, t1;
    arm = 1'b1; event_tooth = 8'd0; event_delay = 24'd55;
    t0 = trig_cnt;
    run_teeth(0, 9);
    checks++; if (trig_cnt !== t0 + 1) begin errors++; $display("FAIL midrev_pre_trig got %0d exp %0d", trig_cnt, t0 + 1); end
    tooth_in = 1'b1;
    repeat (50) @(posedge clk);
    #1 tooth_in = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL midrev_trigger got %0b exp 0", trigger); end
    checks++; if (trigger_delay !== 24'd0) begin errors++; $display("FAIL midrev_delay got %0d exp 0", trigger_delay); end
    checks++; if (tooth_index !== 8'd0) begin errors++; $display("FAIL midrev_index got %0d exp 0", tooth_index); end
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL midrev_synced got %0b exp 0", synced); end
    checks++; if (sync_loss !== 1'b0) begin errors++; $display("FAIL midrev_loss got %0b exp 0", sync_loss); end
    reset_n = 1'b1;
    repeat (29) @(posedge clk);
    #1;
    t1 = trig_cnt;
    run_teeth(11, 34);
    tooth(100);
    checks++; if (synced !== 1'b1 || tooth_index !== 8'd0) begin errors++; $display("FAIL midrev_resync got synced=%0b idx=%0d exp synced=1 idx=0", synced, tooth_index); end
    checks++; if (trig_cnt !== t1) begin errors++; $display("FAIL midrev_first_tooth0 got %0d exp %0d", trig_cnt, t1); end
    run_teeth(1, 34);
    tooth(100);
    checks++; if (trig_cnt !== t1 + 1) begin errors++; $display("FAIL midrev_next_tooth0 got %0d exp %0d", trig_cnt, t1 + 1); end
    checks++; if (last_idx !== 8'd0 || last_dly !== 24'd55) begin errors++; $display("FAIL midrev_trig_vals got idx=%0d dly=%0d exp idx=0 dly=55", last_idx, last_dly); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_sync();
    test_event();
    test_no_fire();
    test_extra_tooth();
    test_stall();
    test_reset_midrev();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL trig_and_loss got %0d exp 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
